// File: rtl/tetris_timing_pkg.sv
// Shared timing defaults and gravity FSM state encoding for the falling-piece timer.
package tetris_timing_pkg;

  localparam int DEF_BASE_TICKS      = 48;
  localparam int DEF_TICKS_PER_LEVEL = 4;
  localparam int DEF_MIN_TICKS       = 2;
  localparam int DEF_SOFT_TICKS      = 1;

  typedef enum logic [1:0] {
    RUN = 2'd0,
    REQ = 2'd1,
    GAP = 2'd2
  } gravity_state_t;

endpackage

// File: rtl/tick_sync.sv
// Multi-flop synchronizer for a slow asynchronous level, followed by a registered
// rising-edge detector producing a one-cycle pulse.
module tick_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   history;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync    <= '0;
      history <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], async_in};
      history <= sync[SYNC_STAGES-1];
      pulse   <= sync[SYNC_STAGES-1] & ~history;
    end
  end

endmodule

// File: rtl/gravity_timer.sv
// Converts game_clk edges into ticks, counts them against a level-dependent fall
// period and issues drop requests over a req/ack handshake with one-deep queueing.
module gravity_timer
  import tetris_timing_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int LEVEL_W         = 4,
  parameter int CNT_W           = 8,
  parameter int BASE_TICKS      = DEF_BASE_TICKS,
  parameter int TICKS_PER_LEVEL = DEF_TICKS_PER_LEVEL,
  parameter int MIN_TICKS       = DEF_MIN_TICKS,
  parameter int SOFT_TICKS      = DEF_SOFT_TICKS
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               game_clk,
  input  logic               pause,
  input  logic [LEVEL_W-1:0] level,
  input  logic               soft_drop,
  input  logic               restart,
  input  logic               drop_ack,
  output logic               drop_req,
  output logic               tick_pulse,
  output logic [CNT_W-1:0]   tick_count,
  output logic               overrun
);

  localparam int WIDE = CNT_W + LEVEL_W + 1;

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("gravity_timer: SYNC_STAGES must be at least 2");
  end
  if (BASE_TICKS >= (1 << CNT_W)) begin : g_bad_width
    $error("gravity_timer: BASE_TICKS does not fit in CNT_W, tick_count could wrap");
  end

  tick_sync #(.SYNC_STAGES(SYNC_STAGES)) u_tick_sync (
    .clock    (clock),
    .reset    (reset),
    .async_in (game_clk),
    .pulse    (tick_pulse)
  );

  logic signed [WIDE-1:0] raw;
  logic signed [WIDE-1:0] period;
  logic signed [WIDE-1:0] next_cnt;
  logic                   count_tick;
  logic                   elapsed;
  logic                   drop_event;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    raw        = $signed(WIDE'(BASE_TICKS))
               - $signed(WIDE'(level)) * $signed(WIDE'(TICKS_PER_LEVEL));
    period     = (raw < $signed(WIDE'(MIN_TICKS))) ? $signed(WIDE'(MIN_TICKS)) : raw;
    if (soft_drop) period = $signed(WIDE'(SOFT_TICKS));
    next_cnt   = $signed(WIDE'(tick_count) + WIDE'(1));
    count_tick = tick_pulse & ~pause;
    elapsed    = next_cnt >= period;
    drop_event = count_tick & elapsed;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tick_count <= '0;
    end else if (restart) begin
      tick_count <= '0;
    end else if (count_tick) begin
      tick_count <= elapsed ? '0 : CNT_W'(next_cnt);
    end
  end

  gravity_state_t state;
  logic           pending;

  // Restart leaves the synchronizer alone so an already-high game_clk cannot re-tick.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      drop_req <= 1'b0;
      pending  <= 1'b0;
      overrun  <= 1'b0;
    end else if (restart) begin
      state    <= RUN;
      drop_req <= 1'b0;
      pending  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (drop_event) begin
            drop_req <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          if (drop_event) begin
            if (pending) overrun <= 1'b1;
            else         pending <= 1'b1;
          end
          if (drop_ack) begin
            drop_req <= 1'b0;
            state    <= (pending || drop_event) ? GAP : RUN;
          end
        end
        GAP: begin
          // The queued drop is being served now; a further event here is lost.
          if (drop_event && pending) overrun <= 1'b1;
          pending  <= 1'b0;
          drop_req <= 1'b1;
          state    <= REQ;
        end
        default: begin
          state    <= RUN;
          drop_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gravity_timer.sv
// Directed bench for gravity_timer: tick latency, fall periods, clamp, queueing,
// pause, restart and the simultaneous ack/event case.
module tb_gravity_timer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       game_clk = 1'b0;
  logic       pause = 1'b0;
  logic [3:0] level = 4'd0;
  logic       soft_drop = 1'b0;
  logic       restart = 1'b0;
  logic       drop_ack = 1'b0;
  logic       drop_req;
  logic       tick_pulse;
  logic [7:0] tick_count;
  logic       overrun;

  int pass_cnt = 0;
  int total_cnt = 0;
  int tick_seen = 0;
  int drops = 0;
  logic prev_req = 1'b0;

  always #5 clock = ~clock;

  gravity_timer dut (
    .clock      (clock),
    .reset      (reset),
    .game_clk   (game_clk),
    .pause      (pause),
    .level      (level),
    .soft_drop  (soft_drop),
    .restart    (restart),
    .drop_ack   (drop_ack),
    .drop_req   (drop_req),
    .tick_pulse (tick_pulse),
    .tick_count (tick_count),
    .overrun    (overrun)
  );

  always @(negedge clock) begin
    if (tick_pulse === 1'b1) tick_seen++;
    if (drop_req === 1'b1 && prev_req !== 1'b1) drops++;
    prev_req = drop_req;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, got timeout want completion");
    $fatal(1, "timeout");
  end

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock) game_clk = 1'b1;
      repeat (4) @(negedge clock);
      game_clk = 1'b0;
      repeat (3) @(negedge clock);
    end
  endtask

  task automatic do_restart();
    @(negedge clock) restart = 1'b1;
    @(negedge clock) restart = 1'b0;
  endtask

  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (tick_pulse === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      total_cnt++;
      if ({drop_req, tick_pulse, overrun, tick_count} !== 11'd0)
        $display("FAIL reset_outputs: got %b want 0", {drop_req, tick_pulse, overrun, tick_count});
      else pass_cnt++;
    end
    @(negedge clock) reset = 1'b1;
    @(negedge clock) game_clk = 1'b1;
    @(negedge clock);
    total_cnt++;
    if (tick_pulse !== 1'b0) $display("FAIL latency_k: got %b want 0", tick_pulse); else pass_cnt++;
    @(negedge clock);
    total_cnt++;
    if (tick_pulse !== 1'b0) $display("FAIL latency_k1: got %b want 0", tick_pulse); else pass_cnt++;
    @(negedge clock);
    total_cnt++;
    if (tick_pulse !== 1'b1) $display("FAIL latency_k2: got %b want 1", tick_pulse); else pass_cnt++;
    @(negedge clock);
    total_cnt++;
    if (tick_pulse !== 1'b0) $display("FAIL latency_k3: got %b want 0", tick_pulse); else pass_cnt++;
    repeat (6) @(negedge clock);
    total_cnt++;
    if (tick_seen !== 1) $display("FAIL held_high_single: got %0d pulses want 1", tick_seen); else pass_cnt++;
    game_clk = 1'b0;
    repeat (4) @(negedge clock);
    total_cnt++;
    if (tick_count !== 8'd1) $display("FAIL first_count: got %0d want 1", tick_count); else pass_cnt++;
  endtask

  task automatic test_level0();
    bit ok;
    int d0;
    do_restart();
    level = 4'd0;
    drop_ack = 1'b1;
    d0 = drops;
    do_ticks(47);
    total_cnt++;
    if (tick_count !== 8'd47 || drops !== d0)
      $display("FAIL level0_47: got count %0d drops %0d want 47 %0d", tick_count, drops, d0);
    else pass_cnt++;
    @(negedge clock) game_clk = 1'b1;
    wait_tick(ok);
    total_cnt++;
    if (!ok) $display("FAIL level0_tick_wait: got timeout want tick_pulse"); else pass_cnt++;
    total_cnt++;
    if (drop_req !== 1'b0 || tick_count !== 8'd47)
      $display("FAIL level0_at_pulse: got req %b count %0d want 0 47", drop_req, tick_count);
    else pass_cnt++;
    @(negedge clock);
    total_cnt++;
    if (drop_req !== 1'b1 || tick_count !== 8'd0)
      $display("FAIL level0_req_rise: got req %b count %0d want 1 0", drop_req, tick_count);
    else pass_cnt++;
    @(negedge clock);
    total_cnt++;
    if (drop_req !== 1'b0) $display("FAIL level0_req_fall: got %b want 0", drop_req); else pass_cnt++;
    game_clk = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic run_clamp(input logic [3:0] lv, input logic sd, input int per);
    int d0;
    do_restart();
    level = lv;
    soft_drop = sd;
    drop_ack = 1'b1;
    d0 = drops;
    do_ticks(per - 1);
    total_cnt++;
    if (drops !== d0 || tick_count !== 8'(per - 1))
      $display("FAIL clamp_pre lv=%0d sd=%b: got drops %0d count %0d want %0d %0d",
               lv, sd, drops - d0, tick_count, 0, per - 1);
    else pass_cnt++;
    do_ticks(1);
    total_cnt++;
    if (drops !== d0 + 1)
      $display("FAIL clamp_first lv=%0d sd=%b: got drops %0d want 1", lv, sd, drops - d0);
    else pass_cnt++;
    do_ticks(2 * per);
    total_cnt++;
    if (drops !== d0 + 3 || tick_count !== 8'd0)
      $display("FAIL clamp_repeat lv=%0d sd=%b: got drops %0d count %0d want 3 0",
               lv, sd, drops - d0, tick_count);
    else pass_cnt++;
    soft_drop = 1'b0;
  endtask

  task automatic test_clamp();
    run_clamp(4'd11, 1'b0, 4);
    run_clamp(4'd12, 1'b0, 2);
    run_clamp(4'd15, 1'b0, 2);
    run_clamp(4'd0,  1'b1, 1);
  endtask

  task automatic test_overrun();
    do_restart();
    level = 4'd15;
    drop_ack = 1'b0;
    do_ticks(1);
    total_cnt++;
    if (drop_req !== 1'b0 || tick_count !== 8'd1)
      $display("FAIL ovr_tick1: got req %b count %0d want 0 1", drop_req, tick_count);
    else pass_cnt++;
    do_ticks(1);
    total_cnt++;
    if (drop_req !== 1'b1) $display("FAIL ovr_tick2_req: got %b want 1", drop_req); else pass_cnt++;
    do_ticks(3);
    total_cnt++;
    if (overrun !== 1'b0 || drop_req !== 1'b1)
      $display("FAIL ovr_tick5: got ovr %b req %b want 0 1", overrun, drop_req);
    else pass_cnt++;
    do_ticks(1);
    total_cnt++;
    if (overrun !== 1'b1) $display("FAIL ovr_tick6: got %b want 1", overrun); else pass_cnt++;
    @(negedge clock) drop_ack = 1'b1;
    @(negedge clock) drop_ack = 1'b0;
    total_cnt++;
    if (drop_req !== 1'b0) $display("FAIL ovr_gap_low: got %b want 0", drop_req); else pass_cnt++;
    @(negedge clock);
    total_cnt++;
    if (drop_req !== 1'b1) $display("FAIL ovr_gap_rehigh: got %b want 1", drop_req); else pass_cnt++;
    drop_ack = 1'b1;
    @(negedge clock) drop_ack = 1'b0;
    repeat (3) @(negedge clock);
    total_cnt++;
    if (drop_req !== 1'b0 || overrun !== 1'b1)
      $display("FAIL ovr_back_to_run: got req %b ovr %b want 0 1", drop_req, overrun);
    else pass_cnt++;
  endtask

  task automatic test_pause();
    int d0;
    int t0;
    do_restart();
    total_cnt++;
    if (overrun !== 1'b0) $display("FAIL pause_restart_ovr: got %b want 0", overrun); else pass_cnt++;
    level = 4'd0;
    drop_ack = 1'b1;
    d0 = drops;
    do_ticks(5);
    pause = 1'b1;
    t0 = tick_seen;
    do_ticks(10);
    total_cnt++;
    if (tick_count !== 8'd5 || drops !== d0 || tick_seen !== t0 + 10)
      $display("FAIL pause_hold: got count %0d drops %0d ticks %0d want 5 0 10",
               tick_count, drops - d0, tick_seen - t0);
    else pass_cnt++;
    pause = 1'b0;
    do_ticks(42);
    total_cnt++;
    if (tick_count !== 8'd47 || drops !== d0)
      $display("FAIL pause_resume_42: got count %0d drops %0d want 47 0", tick_count, drops - d0);
    else pass_cnt++;
    do_ticks(1);
    total_cnt++;
    if (tick_count !== 8'd0 || drops !== d0 + 1)
      $display("FAIL pause_resume_43: got count %0d drops %0d want 0 1", tick_count, drops - d0);
    else pass_cnt++;
  endtask

  task automatic test_restart();
    int t0;
    do_restart();
    level = 4'd15;
    drop_ack = 1'b0;
    do_ticks(6);
    total_cnt++;
    if (drop_req !== 1'b1 || overrun !== 1'b1)
      $display("FAIL rst_setup: got req %b ovr %b want 1 1", drop_req, overrun);
    else pass_cnt++;
    t0 = tick_seen;
    @(negedge clock) restart = 1'b1;
    @(negedge clock) restart = 1'b0;
    total_cnt++;
    if (drop_req !== 1'b0 || overrun !== 1'b0 || tick_count !== 8'd0)
      $display("FAIL rst_clear: got req %b ovr %b count %0d want 0 0 0", drop_req, overrun, tick_count);
    else pass_cnt++;
    repeat (10) @(negedge clock);
    total_cnt++;
    if (tick_seen !== t0 || drop_req !== 1'b0)
      $display("FAIL rst_no_spurious: got ticks %0d req %b want 0 0", tick_seen - t0, drop_req);
    else pass_cnt++;
    do_ticks(2);
    total_cnt++;
    if (drop_req !== 1'b1) $display("FAIL rst_new_req: got %b want 1", drop_req); else pass_cnt++;
    @(negedge clock) drop_ack = 1'b1;
    @(negedge clock) drop_ack = 1'b0;
    repeat (3) @(negedge clock);
    total_cnt++;
    if (drop_req !== 1'b0) $display("FAIL rst_pending_gone: got %b want 0", drop_req); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_restart();
    level = 4'd15;
    drop_ack = 1'b0;
    do_ticks(3);
    total_cnt++;
    if (drop_req !== 1'b1 || tick_count !== 8'd1)
      $display("FAIL b2b_setup: got req %b count %0d want 1 1", drop_req, tick_count);
    else pass_cnt++;
    @(negedge clock) game_clk = 1'b1;
    wait_tick(ok);
    total_cnt++;
    if (!ok) $display("FAIL b2b_tick_wait: got timeout want tick_pulse"); else pass_cnt++;
    drop_ack = 1'b1;
    @(negedge clock) drop_ack = 1'b0;
    total_cnt++;
    if (drop_req !== 1'b0 || tick_count !== 8'd0)
      $display("FAIL b2b_gap: got req %b count %0d want 0 0", drop_req, tick_count);
    else pass_cnt++;
    @(negedge clock);
    total_cnt++;
    if (drop_req !== 1'b1) $display("FAIL b2b_rereq: got %b want 1", drop_req); else pass_cnt++;
    game_clk = 1'b0;
    drop_ack = 1'b1;
    @(negedge clock) drop_ack = 1'b0;
    repeat (4) @(negedge clock);
    total_cnt++;
    if (drop_req !== 1'b0 || overrun !== 1'b0)
      $display("FAIL b2b_done: got req %b ovr %b want 0 0", drop_req, overrun);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_level0();
    test_clamp();
    test_overrun();
    test_pause();
    test_restart();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/gravity_timer.md
Name: gravity_timer

Overview:
- Consumer end of the game-clock interface. Samples the slow game_clk and pause outputs of the clock generator in the system clock domain and converts game_clk rising edges into one-cycle tick pulses.
- Counts those ticks against a level-dependent fall period.
- Issues piece-drop requests to the board controller over a req/ack handshake, queueing at most one extra drop and flagging overruns.

Parameters:
- SYNC_STAGES, 2: synchronizer flops on game_clk (>=2).
- LEVEL_W, 4: width of the level input.
- CNT_W, 8: width of the tick counter and period arithmetic.
- BASE_TICKS, 48: fall period in ticks at level 0.
- TICKS_PER_LEVEL, 4: period reduction per level.
- MIN_TICKS, 2: lower clamp on the fall period.
- SOFT_TICKS, 1: fall period while soft_drop=1.

Ports:
- clock, input, 1: system clock; single clock domain.
- reset, input, 1: asynchronous, active-low reset (0 = reset).
- game_clk, input, 1: slow game clock from the clock generator; asynchronous to clock.
- pause, input, 1: 1 = ignore ticks, hold count.
- level, input, LEVEL_W: current game level.
- soft_drop, input, 1: player holding down; selects SOFT_TICKS.
- restart, input, 1: synchronous clear of the gravity state.
- drop_ack, input, 1: board controller accepted the drop.
- drop_req, output, 1: drop request; held until acknowledged.
- tick_pulse, output, 1: one-cycle pulse per game_clk rising edge.
- tick_count, output, CNT_W: ticks elapsed in the current period.
- overrun, output, 1: sticky; a drop was lost.

Behaviour:
- Reset (reset=0, async): all outputs 0, synchronizer flops 0, edge-detect history 0, counter 0, pending 0, FSM=RUN.
- Tick detection: game_clk passes through SYNC_STAGES flops, then a history flop.
  - tick_pulse = registered (sync_last & ~history).
  - game_clk high at clock edge k produces tick_pulse high in the cycle after edge k+SYNC_STAGES, for exactly one cycle.
  - game_clk held high produces no further pulses.
- Period: lvl = level (all LEVEL_W values legal).
  - raw = BASE_TICKS - lvl*TICKS_PER_LEVEL, computed signed at CNT_W+LEVEL_W+1 bits.
  - period = SOFT_TICKS if soft_drop=1, else max(raw, MIN_TICKS).
  - Re-evaluated every cycle. A level or soft_drop change takes effect at the next tick.
- Counting: on tick_pulse with pause=0:
  - if tick_count+1 >= period, the period has elapsed: tick_count<=0 and a drop event is raised;
  - else tick_count<=tick_count+1.
  - With pause=1, ticks are ignored and tick_count is held.
- FSM states:
  - RUN: drop_req=0. A drop event sets drop_req<=1 next cycle and moves to REQ.
  - REQ: drop_req=1.
    - drop_ack=1 completes the handshake: drop_req<=0 next cycle.
    - If pending=1, go to GAP, else RUN.
  - GAP: drop_req=0 for exactly one cycle, pending<=0, then REQ.
- Drop events during REQ or GAP:
  - pending=0: set pending<=1.
  - pending=1: overrun<=1, sticky.
  - Max one queued drop.
- Simultaneous drop_ack and drop event in REQ: the handshake completes, pending is set, and the FSM goes to GAP.
- drop_ack while drop_req=0: ignored.
- pause never withdraws an asserted drop_req. The handshake completes normally while paused.
- restart=1 (sync, priority over all other events):
  - tick_count, pending, overrun and drop_req cleared; FSM=RUN.
  - Synchronizer and history flops are not cleared, so no spurious tick follows.
- tick_count wrap is impossible: the period is <= BASE_TICKS < 2^CNT_W. This is checked by an elaboration assertion.

Decomposition:
- Package tetris_timing_pkg holds:
  - BASE_TICKS, TICKS_PER_LEVEL, MIN_TICKS, SOFT_TICKS defaults;
  - the FSM state enum {RUN, REQ, GAP}.
- One sub-module, tick_sync: SYNC_STAGES synchronizer plus rising-edge detector, outputs tick_pulse. Also reused for pause if the clock generator is ever moved to another domain.

Test Plan:
- Reset/latency: hold reset=0 for 3 cycles, then release, then raise game_clk. Required: all outputs 0 during reset; tick_pulse high in the cycle after the 2nd edge post-sample, for exactly 1 cycle.
- Level 0 period: level=0, 48 game_clk edges, drop_ack held 1. Required: drop_req rises 1 cycle after the 48th tick_pulse, tick_count returns to 0, falls after ack.
- Clamp boundary: level=11 gives a drop every 4 ticks; level=12 and level=15 give a drop every 2 ticks (MIN_TICKS); soft_drop=1 gives a drop every tick.
- Queue/overrun: level=15, drop_ack=0 for 6 ticks. Required:
  - drop_req=1 after tick 2; pending set at tick 4; overrun=1 at tick 6.
  - Then ack: drop_req low 1 cycle, high again; second ack returns the FSM to RUN.
- Pause: pause=1 at tick_count=5 (level 0) with 10 edges. Required: tick_count stays 5, no drop_req; after pause=0 the drop occurs 43 ticks later.
- Restart mid-REQ: restart=1 while drop_req=1, pending=1, overrun=1. Required: all three are 0 next cycle, tick_count=0, no spurious tick_pulse.
